sigma_mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the shared sigma memory/peripheral bus, using the req/ack/resp handshake.
- Master 0 is the CPU data port; master 1 is the UART debug loader.
- Round-robin arbitration with grant lock while a request is pending.
- Outstanding reads are tracked in an ID FIFO so in-order slave responses return to the issuing master. Adds zero cycles of latency on the request path.

---
 rtl/sigma_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_sigma_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_mem_arbiter.sv
// Two-master round-robin arbiter for the shared sigma bus. A small ID FIFO
// remembers which master issued each outstanding read so in-order responses are steered back.
module sigma_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,

    input  logic                    m0_req_i,
    output logic                    m0_ack_o,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_resp_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_ack_o,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_resp_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    s_req_o,
    input  logic                    s_ack_i,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_resp_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,

    output logic                    err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RESP_DEPTH);

    logic                  lock;
    logic                  locked_id;
    logic                  last_winner;
    logic                  err;
    logic [RESP_DEPTH-1:0] id_fifo;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic                  grant;
    logic                  sel_req;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  orphan_resp;

    // A locked grant sticks to the stalled master; otherwise the idle-side or round-robin choice wins.
    always_comb begin
        grant = ~last_winner;
        if (lock) begin
            grant = locked_id;
        end else if (m0_req_i && !m1_req_i) begin
            grant = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        sel_req   = m0_req_i;
        sel_we    = m0_we_i;
        sel_addr  = m0_addr_i;
        sel_be    = m0_be_i;
        sel_wdata = m0_wdata_i;
        if (grant) begin
            sel_req   = m1_req_i;
            sel_we    = m1_we_i;
            sel_addr  = m1_addr_i;
            sel_be    = m1_be_i;
            sel_wdata = m1_wdata_i;
        end
    end

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign head       = id_fifo[rd_ptr];

    // Reads stall while every response slot is in use; writes never need a slot.
    assign s_req_o   = rst_n_i & sel_req & ~(~sel_we & fifo_full);
    assign s_we_o    = rst_n_i & sel_we;
    assign s_addr_o  = rst_n_i ? sel_addr  : '0;
    assign s_be_o    = rst_n_i ? sel_be    : '0;
    assign s_wdata_o = rst_n_i ? sel_wdata : '0;

    assign accept   = s_req_o & s_ack_i;
    assign push     = accept & ~sel_we;
    assign m0_ack_o = accept & ~grant;
    assign m1_ack_o = accept & grant;

    assign pop         = rst_n_i & s_resp_i & ~fifo_empty;
    assign orphan_resp = s_resp_i & fifo_empty;
    assign m0_resp_o   = pop & ~head;
    assign m1_resp_o   = pop & head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = rst_n_i & err;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lock        <= 1'b0;
            locked_id   <= 1'b0;
            last_winner <= 1'b1;
            err         <= 1'b0;
            id_fifo     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept) begin
                lock        <= 1'b0;
                last_winner <= grant;
            end else if (s_req_o) begin
                lock      <= 1'b1;
                locked_id <= grant;
            end

            if (push) begin
                id_fifo[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end

            if (orphan_resp) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Scoreboard bench for sigma_mem_arbiter: a behavioural slave answers reads,
// expected responses are queued when the bench expects an accepted read.
module tb_sigma_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          m0_req_i, m0_ack_o, m0_we_i, m0_resp_o;
    logic [AW-1:0] m0_addr_i;
    logic [BW-1:0] m0_be_i;
    logic [DW-1:0] m0_wdata_i, m0_rdata_o;
    logic          m1_req_i, m1_ack_o, m1_we_i, m1_resp_o;
    logic [AW-1:0] m1_addr_i;
    logic [BW-1:0] m1_be_i;
    logic [DW-1:0] m1_wdata_i, m1_rdata_o;
    logic          s_req_o, s_ack_i, s_we_o, s_resp_i;
    logic [AW-1:0] s_addr_o;
    logic [BW-1:0] s_be_o;
    logic [DW-1:0] s_wdata_o, s_rdata_i;
    logic          err_o;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] slave_q[$];
    int            resp_limit  = 1000000;
    int            resp_given  = 0;
    int            inject_req  = 0;
    int            inject_done = 0;
    int            compared    = 0;
    int            mismatched  = 0;

    always #5 clk_i = ~clk_i;

    sigma_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_req_i(m0_req_i), .m0_ack_o(m0_ack_o), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_ack_o(m1_ack_o), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_ack_i(s_ack_i), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
        .err_o(err_o)
    );

    function automatic logic [DW-1:0] slaveData(input logic [AW-1:0] addr);
        return {addr[15:0] ^ 16'hC3A5, addr[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                 input logic r1, input logic w1, input logic [AW-1:0] a1,
                                 input logic ack);
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_be_i = 4'hF; m0_wdata_i = ~a0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_be_i = 4'hF; m1_wdata_i = ~a1;
        s_ack_i  = ack;
    endtask

    // Negative exp_* values mean "don't check"; exp_resp is {m1_resp, m0_resp}.
    task automatic stepCycle(input string tag, input logic e0, input logic e1,
                             input int exp_resp, input int exp_sreq, input int exp_err,
                             input bit chk_addr, input logic [AW-1:0] exp_saddr);
        exp_t e;
        @(negedge clk_i);
        checkOutput({tag, "_ack0"}, 32'(m0_ack_o), 32'(e0));
        checkOutput({tag, "_ack1"}, 32'(m1_ack_o), 32'(e1));
        if (exp_resp >= 0) checkOutput({tag, "_resp"}, 32'({m1_resp_o, m0_resp_o}), 32'(exp_resp));
        if (exp_sreq >= 0) checkOutput({tag, "_sreq"}, 32'(s_req_o), 32'(exp_sreq));
        if (exp_err >= 0)  checkOutput({tag, "_err"}, 32'(err_o), 32'(exp_err));
        if (chk_addr) begin
            checkOutput({tag, "_saddr"}, s_addr_o, exp_saddr);
            checkOutput({tag, "_swdata"}, s_wdata_o, (exp_saddr == '0) ? '0 : ~exp_saddr);
            checkOutput({tag, "_sbe"}, 32'(s_be_o), (exp_saddr == '0) ? 32'h0 : 32'hF);
        end
        if (m0_resp_o || m1_resp_o) begin
            if (sb.size() == 0) begin
                checkOutput({tag, "_unexpected_resp"}, 32'({m1_resp_o, m0_resp_o}), 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput({tag, "_resp_id"}, 32'({m1_resp_o, m0_resp_o}), e.id ? 32'h2 : 32'h1);
                checkOutput({tag, "_rdata"}, e.id ? m1_rdata_o : m0_rdata_o, e.data);
            end
        end
        if (e0 && !m0_we_i) sb.push_back('{id: 1'b0, data: slaveData(m0_addr_i)});
        if (e1 && !m1_we_i) sb.push_back('{id: 1'b1, data: slaveData(m1_addr_i)});
        @(posedge clk_i);
        #2;
    endtask

    // Behavioural slave: answers recorded reads in order, one per cycle, within resp_limit.
    initial begin
        s_resp_i  = 1'b0;
        s_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (inject_req > inject_done) begin
                s_resp_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF; inject_done++;
            end else if (resp_given < resp_limit && slave_q.size() > 0) begin
                s_resp_i = 1'b1; s_rdata_i = slaveData(slave_q.pop_front()); resp_given++;
            end else begin
                s_resp_i = 1'b0; s_rdata_i = '0;
            end
            @(negedge clk_i);
            if (!rst_n_i) slave_q.delete();
            else if (s_req_o && s_ack_i && !s_we_o) slave_q.push_back(s_addr_o);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] a0, a1;
        rst_n_i = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk_i);
        #2;

        // Outputs stay quiet during reset even with a live request and ack.
        applyStimulus(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, '0, 1'b1);
        stepCycle("rst0", 0, 0, 0, 0, 0, 1, 32'h0);
        stepCycle("rst1", 0, 0, 0, 0, 0, 1, 32'h0);
        rst_n_i = 1'b1;

        applyStimulus(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1);
        stepCycle("t1_a", 1, 0, 0, 1, 0, 1, 32'h100);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h200, 1'b1);
        stepCycle("t1_b", 0, 1, 1, 1, 0, 1, 32'h200);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        stepCycle("t1_c", 0, 0, 2, 0, 0, 0, '0);

        applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 1'b0);
        for (int i = 0; i < 3; i++) stepCycle("t2_wait", 0, 0, 0, 1, -1, 1, 32'h300);
        s_ack_i = 1'b1;
        stepCycle("t2_acc", 1, 0, 0, 1, -1, 1, 32'h300);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h400, 1'b1);
        stepCycle("t2_m1", 0, 1, 0, 1, -1, 1, 32'h400);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        stepCycle("t2_resp", 0, 0, 2, 0, -1, 0, '0);

        // m1 is stalled first; the lock must keep m0 out although round-robin would favour it.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h500, 1'b0);
        stepCycle("lk_a", 0, 0, 0, 1, -1, 1, 32'h500);
        applyStimulus(1'b1, 1'b1, 32'h510, 1'b1, 1'b1, 32'h500, 1'b0);
        stepCycle("lk_b", 0, 0, 0, 1, -1, 1, 32'h500);
        s_ack_i = 1'b1;
        stepCycle("lk_c", 0, 1, 0, 1, -1, 1, 32'h500);
        applyStimulus(1'b1, 1'b1, 32'h510, 1'b0, 1'b0, '0, 1'b1);
        stepCycle("lk_d", 1, 0, 0, 1, -1, 1, 32'h510);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h520, 1'b1);
        stepCycle("lk_e", 0, 1, 0, 1, -1, 1, 32'h520);

        a0 = 32'h1000;
        a1 = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, a0, 1'b1, 1'b1, a1, 1'b1);
            stepCycle("t3_rr", (i % 2 == 0), (i % 2 == 1), (i % 2 == 1) ? 1 : 0, 1, -1, 1,
                      (i % 2 == 0) ? a0 : a1);
            if (i % 2 == 0) a0 = a0 + 4; else a1 = a1 + 4;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        stepCycle("t3_idle", 0, 0, 0, 0, -1, 0, '0);

        resp_limit = resp_given;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h3000 + 32'(4 * j), 1'b1);
            stepCycle("t4_fill", 0, 1, 0, 1, -1, 1, 32'h3000 + 32'(4 * j));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h3010, 1'b1);
        stepCycle("t4_full", 0, 0, 0, 0, -1, 0, '0);
        applyStimulus(1'b1, 1'b1, 32'h3100, 1'b1, 1'b0, 32'h3010, 1'b1);
        resp_limit = resp_given + 1;
        stepCycle("t4_wr", 1, 0, 0, 1, -1, 1, 32'h3100);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h3010, 1'b1);
        stepCycle("t4_pop", 0, 0, 2, 0, -1, 0, '0);
        resp_limit = 1000000;
        stepCycle("t4_unblk", 0, 1, 0, 1, -1, 1, 32'h3010);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        for (int j = 0; j < 4; j++) stepCycle("t4_drain", 0, 0, 2, 0, -1, 0, '0);
        stepCycle("t4_done", 0, 0, 0, 0, 0, 0, '0);
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'h0);

        inject_req++;
        stepCycle("t5_a", 0, 0, 0, 0, 0, 0, '0);
        stepCycle("t5_orphan", 0, 0, 0, 0, 0, 0, '0);
        stepCycle("t5_err", 0, 0, 0, 0, 1, 0, '0);
        stepCycle("t5_sticky", 0, 0, 0, 0, 1, 0, '0);
        rst_n_i = 1'b0;
        stepCycle("t5_rst", 0, 0, 0, 0, 0, 0, '0);
        rst_n_i = 1'b1;
        stepCycle("t5_clr", 0, 0, 0, 0, 0, 0, '0);

        resp_limit = resp_given;
        applyStimulus(1'b1, 1'b0, 32'h600, 1'b0, 1'b0, '0, 1'b1);
        stepCycle("t6_rd0", 1, 0, 0, 1, 0, 1, 32'h600);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h700, 1'b1);
        stepCycle("t6_rd1", 0, 1, 0, 1, 0, 1, 32'h700);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        rst_n_i = 1'b0;
        sb.delete();
        stepCycle("t6_rst", 0, 0, 0, 0, 0, 0, '0);
        rst_n_i = 1'b1;
        inject_req += 2;
        stepCycle("t6_r1", 0, 0, 0, 0, 0, 0, '0);
        stepCycle("t6_late0", 0, 0, 0, 0, 0, 0, '0);
        stepCycle("t6_late1", 0, 0, 0, 0, 1, 0, '0);
        stepCycle("t6_err", 0, 0, 0, 0, 1, 0, '0);
        checkOutput("t6_sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
